light_seq: RTL and testbench

LIGHT_SEQ -- requirements
Module: light_seq

---
 rtl/light_seq.sv | 132 +++++++++++++
 tb/tb_light_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/light_seq.sv
// light_seq: lamp driver with optional power-on lamp walk, direct lamp
// selection and an alarm blink.
// Build option: define LIGHT_SEQ_LAMP_TEST_EN to compile in the power-on walk
// (WALK state, walk index and busy flag); without it reset enters RUN.
module light_seq #(
  parameter int unsigned NL  = 4,
  parameter int unsigned DIV = 25000000,
  localparam int unsigned MW = $clog2(NL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [MW-1:0] mode,
  input  logic          mode_vld,
  input  logic          alarm,
  output logic [NL-1:0] lamp,
  output logic          busy
);

  localparam int unsigned CW = $clog2(DIV);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
`ifdef LIGHT_SEQ_LAMP_TEST_EN
    S_WALK  = 2'd2,
`endif
    S_ALARM = 2'd1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   mreg_q, mreg_d;
  logic [NL-1:0]   lamp_q, lamp_d;
  logic            tick;
`ifdef LIGHT_SEQ_LAMP_TEST_EN
  logic [MW-1:0]   widx_q, widx_d;
  logic            busy_q, busy_d;
`endif

  // One-hot decode of a lamp index; out-of-range indices light nothing.
  function automatic logic [NL-1:0] onehot(input logic [MW-1:0] idx);
    if (32'(idx) < NL) return NL'(1) << idx;
    else               return '0;
  endfunction

  assign tick = (cnt_q == CW'(DIV - 1));

  // Next-state, counter, mode register and lamp pattern.
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    mreg_d  = mode_vld ? mode : mreg_q;
    lamp_d  = lamp_q;
`ifdef LIGHT_SEQ_LAMP_TEST_EN
    widx_d  = widx_q;
`endif
    case (state_q)
`ifdef LIGHT_SEQ_LAMP_TEST_EN
      S_WALK: begin
        if (alarm) begin
          state_d = S_ALARM;
          cnt_d   = '0;
          lamp_d  = '1;
        end else begin
          // lamp trails widx by one clock so every walk slot lasts DIV clocks
          lamp_d = onehot(widx_q);
          if (tick) begin
            if (widx_q == MW'(NL - 1)) state_d = S_RUN;
            else                       widx_d  = widx_q + MW'(1);
          end
        end
      end
`endif
      S_RUN: begin
        if (alarm) begin
          state_d = S_ALARM;
          cnt_d   = '0;
          lamp_d  = '1;
        end else begin
          lamp_d = onehot(mreg_d);
        end
      end
      S_ALARM: begin
        if (!alarm) begin
          state_d = S_RUN;
          lamp_d  = onehot(mreg_d);
        end else if (tick) begin
          lamp_d = ~lamp_q;
        end
      end
      default: begin
        state_d = S_RUN;
        lamp_d  = onehot(mreg_d);
      end
    endcase
`ifdef LIGHT_SEQ_LAMP_TEST_EN
    busy_d = (state_d == S_WALK);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LIGHT_SEQ_LAMP_TEST_EN
      state_q <= S_WALK;
      widx_q  <= '0;
      busy_q  <= 1'b0;
`else
      state_q <= S_RUN;
`endif
      cnt_q   <= '0;
      mreg_q  <= '0;
      lamp_q  <= '0;
    end else begin
`ifdef LIGHT_SEQ_LAMP_TEST_EN
      widx_q  <= widx_d;
      busy_q  <= busy_d;
`endif
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mreg_q  <= mreg_d;
      lamp_q  <= lamp_d;
    end
  end

  assign lamp = lamp_q;
`ifdef LIGHT_SEQ_LAMP_TEST_EN
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_light_seq.sv
// Directed bench for light_seq (NL=4 and NL=3, DIV=4); expectations follow
// LIGHT_SEQ_LAMP_TEST_EN when it is defined for the build.
module tb_light_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode, mode3;
  logic       mode_vld, mode_vld3;
  logic       alarm, alarm3;
  logic [3:0] lamp;
  logic [2:0] lamp3;
  logic       busy, busy3;

  int n_tests = 0;
  int n_fail  = 0;

  light_seq #(.NL(4), .DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .mode_vld(mode_vld),
    .alarm(alarm), .lamp(lamp), .busy(busy)
  );

  light_seq #(.NL(3), .DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .mode_vld(mode_vld3),
    .alarm(alarm3), .lamp(lamp3), .busy(busy3)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; alarm = 1'b0; mode = 2'd0; mode_vld = 1'b0;
    alarm3 = 1'b0; mode3 = 2'd0; mode_vld3 = 1'b0;
    repeat (3) step();
    chk("reset_lamp", 16'(lamp), 16'h0);
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_lamp3", 16'(lamp3), 16'h0);
    #2 rst_n = 1'b1;

`ifdef LIGHT_SEQ_LAMP_TEST_EN
    // Power-on walk: four slots of four clocks, busy drops with RUN entry.
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("walk_lamp_%0d", i), 16'(lamp), 16'(4'b0001 << ((i - 1) / 4)));
      chk($sformatf("walk_busy_%0d", i), 16'(busy), 16'(i < 16));
      if (i == 1) chk("first_lamp3", 16'(lamp3), 16'h1);
    end
    step();
    chk("walk_end_lamp", 16'(lamp), 16'h1);
    chk("walk_end_busy", 16'(busy), 16'h0);
`else
    step();
    chk("first_lamp", 16'(lamp), 16'h1);
    chk("first_lamp3", 16'(lamp3), 16'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("busy_const0", 16'(busy), 16'h0);
    end
`endif

    // Mode select in RUN: visible at the sampling edge, then held.
    mode = 2'd2; mode_vld = 1'b1;
    step();
    mode_vld = 1'b0; mode = 2'd0;
    chk("mode2_lamp", 16'(lamp), 16'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mode2_hold", 16'(lamp), 16'h4);
    end

    // Alarm blink for 12 clocks, then return to the selected lamp.
    alarm = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      chk($sformatf("blink_%0d", j), 16'(lamp), ((j / 4) % 2 == 0) ? 16'hf : 16'h0);
    end
    alarm = 1'b0;
    step();
    chk("alarm_exit_lamp", 16'(lamp), 16'h4);
    chk("alarm_exit_busy", 16'(busy), 16'h0);

    // mode_vld together with alarm entry: alarm wins lamp, mreg still loads.
    mode = 2'd1; mode_vld = 1'b1; alarm = 1'b1;
    step();
    mode_vld = 1'b0; alarm = 1'b0;
    chk("coincide_lamp", 16'(lamp), 16'hf);
    step();
    chk("coincide_exit", 16'(lamp), 16'h2);

    // Reset in the middle of a blink.
    alarm = 1'b1;
    repeat (6) step();
    chk("midblink_lamp", 16'(lamp), 16'h0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_lamp", 16'(lamp), 16'h0);
    chk("async_reset_busy", 16'(busy), 16'h0);
    alarm = 1'b0;
    step();
    chk("reset_hold_lamp", 16'(lamp), 16'h0);
    #2 rst_n = 1'b1;

`ifdef LIGHT_SEQ_LAMP_TEST_EN
    // Walk restarts, then alarm during step 2 aborts it for good.
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("rewalk_lamp_%0d", i), 16'(lamp), 16'(4'b0001 << ((i - 1) / 4)));
      chk($sformatf("rewalk_busy_%0d", i), 16'(busy), 16'h1);
    end
    alarm = 1'b1;
    step();
    alarm = 1'b0;
    chk("abort_lamp", 16'(lamp), 16'hf);
    chk("abort_busy", 16'(busy), 16'h0);
    step();
    chk("abort_run_lamp", 16'(lamp), 16'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_resume_lamp", 16'(lamp), 16'h1);
      chk("no_resume_busy", 16'(busy), 16'h0);
    end
`else
    step();
    chk("rerun_lamp", 16'(lamp), 16'h1);
    chk("rerun_busy", 16'(busy), 16'h0);
`endif

    // NL=3: out-of-range index lights nothing.
    repeat (14) step();
    mode3 = 2'd3; mode_vld3 = 1'b1;
    step();
    mode_vld3 = 1'b0;
    chk("nl3_mode3_lamp", 16'(lamp3), 16'h0);
    chk("nl3_busy", 16'(busy3), 16'h0);
    step();
    chk("nl3_mode3_hold", 16'(lamp3), 16'h0);
    mode3 = 2'd2; mode_vld3 = 1'b1;
    step();
    mode_vld3 = 1'b0;
    chk("nl3_mode2_lamp", 16'(lamp3), 16'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
